// File: rtl/cordic_rot_sched.sv
// cordic_rot_sched: iterative CORDIC rotation scheduler for the FFT twiddle path.
// Two butterfly lanes share one shift-add micro-rotation stage that is reused
// for ITERS cycles per request. Requests are arbitrated round-robin and
// quadrant pre-rotated by k*90 deg before iterating. CORDIC gain (~1.6468) is
// left uncompensated.
//
// Ports:
//   clk_i, rst_ni                       clock, async active-low reset
//   reqN_valid_i / reqN_ready_o         request handshake, lane N in {0,1}
//   reqN_real_i, reqN_img_i             signed input vector
//   reqN_z_i                            signed residual angle, 1 LSB = 1/512 deg
//   reqN_quad_i                         quadrant pre-rotation, k*90 deg
//   out_valid_o / out_ready_i           result handshake
//   out_real_o, out_img_o, out_src_o    rotated vector and issuing lane
//   busy_o                              high whenever not idle
module cordic_rot_sched #(
    parameter int ITERS = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic signed [15:0] req0_real_i,
    input  logic signed [15:0] req0_img_i,
    input  logic signed [15:0] req0_z_i,
    input  logic [1:0]         req0_quad_i,
    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic signed [15:0] req1_real_i,
    input  logic signed [15:0] req1_img_i,
    input  logic signed [15:0] req1_z_i,
    input  logic [1:0]         req1_quad_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic signed [15:0] out_real_o,
    output logic signed [15:0] out_img_o,
    output logic               out_src_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

    localparam logic [3:0] LAST = 4'(ITERS - 1);

    // atan(2^-i) in 1/512 degree units
    function automatic logic signed [15:0] theta(input logic [3:0] i);
        case (i)
            4'd0:    theta = 16'sd23040;
            4'd1:    theta = 16'sd13601;
            4'd2:    theta = 16'sd7187;
            4'd3:    theta = 16'sd3648;
            4'd4:    theta = 16'sd1831;
            4'd5:    theta = 16'sd916;
            4'd6:    theta = 16'sd458;
            4'd7:    theta = 16'sd229;
            4'd8:    theta = 16'sd115;
            4'd9:    theta = 16'sd57;
            4'd10:   theta = 16'sd29;
            4'd11:   theta = 16'sd14;
            4'd12:   theta = 16'sd7;
            4'd13:   theta = 16'sd4;
            4'd14:   theta = 16'sd2;
            default: theta = 16'sd1;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               last_src_q, last_src_d;
    logic               src_q, src_d;
    logic signed [15:0] x_q, x_d, y_q, y_d, z_q, z_d;

    logic               any_req, gsel, grant_ok;
    logic signed [15:0] in_x, in_y, in_z, pre_x, pre_y;
    logic [1:0]         in_q;
    logic signed [15:0] x_sh, y_sh, x_rot, y_rot, z_rot;

    // Arbitration: a lone requester wins; on a tie the lane that did not
    // go last wins. Ready is suppressed while reset is held.
    always_comb begin
        any_req      = req0_valid_i | req1_valid_i;
        gsel         = (req0_valid_i & req1_valid_i) ? ~last_src_q : req1_valid_i;
        grant_ok     = rst_ni & (state_q == IDLE) & any_req;
        req0_ready_o = grant_ok & ~gsel;
        req1_ready_o = grant_ok & gsel;
    end

    // Quadrant pre-rotation of the granted lane; negation wraps at 16 bits
    always_comb begin
        in_x  = gsel ? req1_real_i : req0_real_i;
        in_y  = gsel ? req1_img_i  : req0_img_i;
        in_z  = gsel ? req1_z_i    : req0_z_i;
        in_q  = gsel ? req1_quad_i : req0_quad_i;
        pre_x = in_x;
        pre_y = in_y;
        case (in_q)
            2'd0: begin pre_x = in_x;  pre_y = in_y;  end
            2'd1: begin pre_x = -in_y; pre_y = in_x;  end
            2'd2: begin pre_x = -in_x; pre_y = -in_y; end
            default: begin pre_x = in_y; pre_y = -in_x; end
        endcase
    end

    // One micro-rotation, direction chosen by the sign of the residual angle
    always_comb begin
        x_sh = x_q >>> cnt_q;
        y_sh = y_q >>> cnt_q;
        if (z_q[15]) begin
            x_rot = x_q + y_sh;
            y_rot = y_q - x_sh;
            z_rot = z_q + theta(cnt_q);
        end else begin
            x_rot = x_q - y_sh;
            y_rot = y_q + x_sh;
            z_rot = z_q - theta(cnt_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_src_d = last_src_q;
        src_d      = src_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = ROT;
                    cnt_d      = 4'd0;
                    src_d      = gsel;
                    last_src_d = gsel;
                    x_d        = pre_x;
                    y_d        = pre_y;
                    z_d        = in_z;
                end
            end
            ROT: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                if (cnt_q == LAST) state_d = DONE;
                else               cnt_d   = cnt_q + 4'd1;
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            last_src_q <= 1'b1;
            src_q      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_src_q <= last_src_d;
            src_q      <= src_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
        end
    end

    // The working registers double as the result registers: they only move
    // in ROT, so they are stable for the whole of DONE.
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign out_real_o  = x_q;
    assign out_img_o   = y_q;
    assign out_src_o   = src_q;

endmodule
